menu_cursor_ctrl: RTL and testbench
===================================

Name: menu_cursor_ctrl

Overview:
- Upstream control stage for the background/overlay colour mixer.
- Debounces the five push-buttons and runs the on-screen settings menu state machine.
- Holds the display settings (axis/grid/tick enables, colour scheme) and the menu cursor.
- Generates registered per-pixel menu box, border and cursor-highlight conditions from the VGA coordinates; the mixer consumes all of these directly.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, CLK_VGA cycles a raw button must stay stable before it is accepted (10 ms at 108 MHz, rounded)
- MENU_X0, 40, left pixel column of menu box
- MENU_Y0, 40, top pixel row of menu box
- ITEM_W, 240, menu box width in pixels
- ITEM_H, 32, height of one menu row in pixels
- N_ITEMS, 4, number of menu rows (fixed item map below; must be 4)
- BORDER, 2, border and inset thickness in pixels

Ports:
- CLK_VGA  in  1  pixel clock; only clock
- RESET_N  in  1  asynchronous active-low reset
- BTN_C, BTN_U, BTN_D, BTN_L, BTN_R  in  1 each  raw, asynchronous push-buttons, active-high
- VGA_HORZ_COORD  in  12  current pixel x
- VGA_VERT_COORD  in  12  current pixel y
- Axis_On  out  1  axis enable
- Grid_On  out  1  grid enable
- Tick_On  out  1  tick enable
- Color_Scheme  out  2  palette select 0..3
- Menu_Open  out  1  high while the menu is displayed
- Cursor_Index  out  2  selected row 0..3
- Condition_For_Menu_Box  out  1  pixel is inside the menu box
- Condition_For_Menu_Border  out  1  pixel is on the menu border
- Condition_For_Cursor_Menu  out  1  pixel is inside the highlight of the selected row

Behaviour:
- Reset (async assert, sync release) values:
  - Axis_On=1, Grid_On=1, Tick_On=1, Color_Scheme=0
  - Menu_Open=0, Cursor_Index=0
  - all Condition_* outputs 0
  - debounce counters 0; stable button state 0
- Button input path, per button:
  - 2-flop synchroniser.
  - Counter counts while the synchronised value differs from the stable state and clears when they match.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable state takes the new value and the counter clears.
  - A 1-cycle press pulse fires on the stable 0->1 transition only; release produces no pulse.
  - Latency: raw edge to pulse = 2 + DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
- Simultaneous pulses: priority C > U > D > R > L. Only the highest-priority pulse is acted on that cycle; the rest are discarded, not queued.
- State machine, 2 states:
  - CLOSED: C -> OPEN. All other buttons are ignored.
  - OPEN: C -> CLOSED. U: Cursor_Index-1 mod 4. D: Cursor_Index+1 mod 4. Cursor wraps 0<->3.
- Item map and edits, applied in OPEN on R/L:
  - row 0: Axis_On toggles on either R or L
  - row 1: Grid_On toggles on either R or L
  - row 2: Tick_On toggles on either R or L
  - row 3: Color_Scheme +1 mod 4 on R, -1 mod 4 on L; 3->0 and 0->3 wrap
- Settings and output timing:
  - Settings and Cursor_Index update on the clock edge after the pulse.
  - Closing the menu retains Cursor_Index and all settings.
  - Menu_Open is the registered state bit.
- Pixel conditions, registered with 1-cycle latency from the coordinate inputs and forced 0 when CLOSED:
  - Box: MENU_X0 <= x < MENU_X0+ITEM_W and MENU_Y0 <= y < MENU_Y0+N_ITEMS*ITEM_H.
  - Border: Box, and x or y lies within BORDER px of any box edge.
  - Cursor_Menu: y in the selected row (MENU_Y0+Cursor_Index*ITEM_H ... +ITEM_H-1), inset BORDER px on all four sides, and not Border.
  - Box stays high on Border and Cursor_Menu pixels; priority among them is resolved downstream.
  - Comparisons are 12-bit unsigned. Bounds are computed from constants so there is no overflow; out-of-range coordinates simply give 0.
- Mid-frame changes: a state or cursor change takes effect on the next pixel. No frame synchronisation is required.
- Reset mid-debounce discards the pending press.

Decomposition:
- Shared package holds:
  - FSM state encoding (ST_CLOSED, ST_OPEN)
  - item indices (ITEM_AXIS=0, ITEM_GRID=1, ITEM_TICK=2, ITEM_COLOUR=3)
  - default settings constants
- One sub-module: button_debounce (sync + counter + press pulse, parameter DEBOUNCE_CYCLES), instantiated five times.

Test Plan (sim with DEBOUNCE_CYCLES=4):
- Reset, no buttons -> Axis/Grid/Tick=1, Color_Scheme=0, Menu_Open=0, Cursor_Index=0; coordinate (50,50) gives Box=0.
- BTN_C held 10 cycles -> Menu_Open=1 exactly 7 cycles after the raw edge. Coordinate (40,40) -> Box=1, Border=1 one cycle later. (50,50) -> Box=1, Border=0, Cursor_Menu=1. (50,80) -> Cursor_Menu=0.
- Menu open, BTN_U once -> Cursor_Index=3 (wrap). Then BTN_R x2 -> Color_Scheme 1 then 2. Then BTN_L x3 -> 1, 0, 3.
- Cursor at 1, BTN_R -> Grid_On=0. BTN_C -> Menu_Open=0, Grid_On stays 0, all Conditions 0. BTN_D while CLOSED -> Cursor_Index unchanged.
- 2-cycle glitch on BTN_D -> no change. BTN_U and BTN_D stable on the same cycle -> only U applied (index-1).
- RESET_N pulsed low mid-debounce with Grid_On=0 -> outputs return to reset values immediately, with no clock required; no pulse after release.

Source files
------------

// File: rtl/menu_cursor_ctrl_pkg.sv
// Shared types and constants for the settings menu: FSM states, decoded button
// actions, button/item indices and power-up settings.
package menu_cursor_ctrl_pkg;

  typedef enum logic {
    ST_CLOSED = 1'b0,
    ST_OPEN   = 1'b1
  } menu_state_t;

  typedef enum logic [2:0] {
    ACT_NONE = 3'd0,
    ACT_C    = 3'd1,
    ACT_U    = 3'd2,
    ACT_D    = 3'd3,
    ACT_R    = 3'd4,
    ACT_L    = 3'd5
  } menu_action_t;

  localparam int N_BUTTONS = 5;

  // Index order doubles as arbitration order: lower index wins.
  localparam int BTN_C_IDX = 0;
  localparam int BTN_U_IDX = 1;
  localparam int BTN_D_IDX = 2;
  localparam int BTN_R_IDX = 3;
  localparam int BTN_L_IDX = 4;

  localparam logic [1:0] ITEM_AXIS   = 2'd0;
  localparam logic [1:0] ITEM_GRID   = 2'd1;
  localparam logic [1:0] ITEM_TICK   = 2'd2;
  localparam logic [1:0] ITEM_COLOUR = 2'd3;

  localparam logic       DEF_AXIS_ON      = 1'b1;
  localparam logic       DEF_GRID_ON      = 1'b1;
  localparam logic       DEF_TICK_ON      = 1'b1;
  localparam logic [1:0] DEF_COLOR_SCHEME = 2'd0;
  localparam logic [1:0] DEF_CURSOR       = 2'd0;

  // Palette select steps with natural mod-4 wrap in both directions.
  function automatic logic [1:0] colour_step(input logic [1:0] scheme, input logic up);
    return up ? (scheme + 2'd1) : (scheme - 2'd1);
  endfunction

endpackage

// File: rtl/menu_cursor_ctrl_button_debounce.sv
// Push-button conditioner: 2-flop synchroniser, stability counter and a
// registered one-cycle pulse on each accepted press (release is silent).
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          stable_reg;
  logic          press_reg;
  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg  <= 1'b0;
      sync2_reg  <= 1'b0;
      stable_reg <= 1'b0;
      press_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      sync1_reg <= btn_raw;
      sync2_reg <= sync1_reg;
      press_reg <= 1'b0;
      if (sync2_reg == stable_reg) begin
        cnt_reg <= '0;
      end else if (cnt_reg == CNT_LAST) begin
        // Level held long enough: accept it and flag only rising acceptances.
        stable_reg <= sync2_reg;
        press_reg  <= sync2_reg;
        cnt_reg    <= '0;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end
    end
  end

  assign press = press_reg;

endmodule

// File: rtl/menu_cursor_ctrl.sv
// Settings menu controller: debounced buttons drive an open/closed menu FSM,
// the display settings and cursor, and registered per-pixel menu conditions.
module menu_cursor_ctrl
  import menu_cursor_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MENU_X0         = 40,
  parameter int MENU_Y0         = 40,
  parameter int ITEM_W          = 240,
  parameter int ITEM_H          = 32,
  parameter int N_ITEMS         = 4,
  parameter int BORDER          = 2
) (
  input  logic        CLK_VGA,
  input  logic        RESET_N,
  input  logic        BTN_C,
  input  logic        BTN_U,
  input  logic        BTN_D,
  input  logic        BTN_L,
  input  logic        BTN_R,
  input  logic [11:0] VGA_HORZ_COORD,
  input  logic [11:0] VGA_VERT_COORD,
  output logic        Axis_On,
  output logic        Grid_On,
  output logic        Tick_On,
  output logic [1:0]  Color_Scheme,
  output logic        Menu_Open,
  output logic [1:0]  Cursor_Index,
  output logic        Condition_For_Menu_Box,
  output logic        Condition_For_Menu_Border,
  output logic        Condition_For_Cursor_Menu
);

  // Box geometry, all fixed at elaboration and well inside 12 bits.
  localparam logic [11:0] BOX_X0 = 12'(MENU_X0);
  localparam logic [11:0] BOX_X1 = 12'(MENU_X0 + ITEM_W);
  localparam logic [11:0] BOX_Y0 = 12'(MENU_Y0);
  localparam logic [11:0] BOX_Y1 = 12'(MENU_Y0 + N_ITEMS * ITEM_H);
  localparam logic [11:0] IN_X0  = 12'(MENU_X0 + BORDER);
  localparam logic [11:0] IN_X1  = 12'(MENU_X0 + ITEM_W - BORDER);
  localparam logic [11:0] IN_Y0  = 12'(MENU_Y0 + BORDER);
  localparam logic [11:0] IN_Y1  = 12'(MENU_Y0 + N_ITEMS * ITEM_H - BORDER);
  localparam logic [11:0] ROW_H  = 12'(ITEM_H);
  localparam logic [11:0] INSET  = 12'(BORDER);

  logic [N_BUTTONS-1:0] btn_raw;
  logic [N_BUTTONS-1:0] press;
  menu_action_t         action;

  menu_state_t state_reg;
  menu_state_t state_next;
  logic        menu_open;
  logic        edit_en;

  logic       axis_reg;
  logic       grid_reg;
  logic       tick_reg;
  logic [1:0] scheme_reg;
  logic [1:0] cursor_reg;

  logic        box_reg;
  logic        border_reg;
  logic        highlight_reg;
  logic        in_box;
  logic        in_inner;
  logic        on_border;
  logic        in_highlight;
  logic [11:0] row_top;
  logic [11:0] row_lo;
  logic [11:0] row_hi;

  assign btn_raw = {BTN_L, BTN_R, BTN_D, BTN_U, BTN_C};

  generate
    for (genvar gi = 0; gi < N_BUTTONS; gi++) begin : g_btn
      button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
        .clk    (CLK_VGA),
        .rst_n  (RESET_N),
        .btn_raw(btn_raw[gi]),
        .press  (press[gi])
      );
    end
  endgenerate

  // Only the highest-priority pulse survives; the others are dropped.
  always_comb begin
    action = ACT_NONE;
    if (press[BTN_C_IDX])      action = ACT_C;
    else if (press[BTN_U_IDX]) action = ACT_U;
    else if (press[BTN_D_IDX]) action = ACT_D;
    else if (press[BTN_R_IDX]) action = ACT_R;
    else if (press[BTN_L_IDX]) action = ACT_L;
  end

  always_ff @(posedge CLK_VGA or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg <= ST_CLOSED;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_CLOSED: if (action == ACT_C) state_next = ST_OPEN;
      ST_OPEN:   if (action == ACT_C) state_next = ST_CLOSED;
      default:   state_next = ST_CLOSED;
    endcase
  end

  always_comb begin
    menu_open = 1'b0;
    edit_en   = 1'b0;
    if (state_reg == ST_OPEN) begin
      menu_open = 1'b1;
      edit_en   = (action != ACT_C);
    end
  end

  always_ff @(posedge CLK_VGA or negedge RESET_N) begin
    if (!RESET_N) begin
      axis_reg   <= DEF_AXIS_ON;
      grid_reg   <= DEF_GRID_ON;
      tick_reg   <= DEF_TICK_ON;
      scheme_reg <= DEF_COLOR_SCHEME;
      cursor_reg <= DEF_CURSOR;
    end else if (edit_en) begin
      case (action)
        ACT_U: cursor_reg <= cursor_reg - 2'd1;
        ACT_D: cursor_reg <= cursor_reg + 2'd1;
        ACT_R, ACT_L: begin
          case (cursor_reg)
            ITEM_AXIS:   axis_reg   <= ~axis_reg;
            ITEM_GRID:   grid_reg   <= ~grid_reg;
            ITEM_TICK:   tick_reg   <= ~tick_reg;
            ITEM_COLOUR: scheme_reg <= colour_step(scheme_reg, action == ACT_R);
            default:     scheme_reg <= scheme_reg;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Selected row spans [row_top, row_top+ITEM_H); highlight is inset on all sides.
  always_comb begin
    row_top = BOX_Y0 + (12'(cursor_reg) * ROW_H);
    row_lo  = row_top + INSET;
    row_hi  = row_top + ROW_H - INSET;
    in_box  = (VGA_HORZ_COORD >= BOX_X0) && (VGA_HORZ_COORD < BOX_X1) &&
              (VGA_VERT_COORD >= BOX_Y0) && (VGA_VERT_COORD < BOX_Y1);
    in_inner = (VGA_HORZ_COORD >= IN_X0) && (VGA_HORZ_COORD < IN_X1) &&
               (VGA_VERT_COORD >= IN_Y0) && (VGA_VERT_COORD < IN_Y1);
    on_border    = in_box && !in_inner;
    in_highlight = (VGA_VERT_COORD >= row_lo) && (VGA_VERT_COORD < row_hi) &&
                   (VGA_HORZ_COORD >= IN_X0) && (VGA_HORZ_COORD < IN_X1) &&
                   !on_border;
  end

  always_ff @(posedge CLK_VGA or negedge RESET_N) begin
    if (!RESET_N) begin
      box_reg       <= 1'b0;
      border_reg    <= 1'b0;
      highlight_reg <= 1'b0;
    end else begin
      box_reg       <= menu_open && in_box;
      border_reg    <= menu_open && on_border;
      highlight_reg <= menu_open && in_highlight;
    end
  end

  assign Axis_On                   = axis_reg;
  assign Grid_On                   = grid_reg;
  assign Tick_On                   = tick_reg;
  assign Color_Scheme              = scheme_reg;
  assign Menu_Open                 = menu_open;
  assign Cursor_Index              = cursor_reg;
  assign Condition_For_Menu_Box    = box_reg;
  assign Condition_For_Menu_Border = border_reg;
  assign Condition_For_Cursor_Menu = highlight_reg;

endmodule

// File: tb/tb_menu_cursor_ctrl.sv
// Bench for menu_cursor_ctrl: directed scenarios with literal expectations, then
// random buttons/coordinates checked every cycle against a behavioural model.
module tb_menu_cursor_ctrl;

  localparam int TB_DEB = 4;

  logic        CLK_VGA = 1'b0;
  logic        RESET_N = 1'b0;
  logic [4:0]  btn = '0;  // 0:C 1:U 2:D 3:R 4:L
  logic [11:0] VGA_HORZ_COORD = 12'd50;
  logic [11:0] VGA_VERT_COORD = 12'd50;
  logic        Axis_On, Grid_On, Tick_On, Menu_Open;
  logic [1:0]  Color_Scheme, Cursor_Index;
  logic        Condition_For_Menu_Box, Condition_For_Menu_Border, Condition_For_Cursor_Menu;

  int n_checks = 0;
  int n_errors = 0;

  menu_cursor_ctrl #(.DEBOUNCE_CYCLES(TB_DEB)) dut (
    .CLK_VGA                  (CLK_VGA),
    .RESET_N                  (RESET_N),
    .BTN_C                    (btn[0]),
    .BTN_U                    (btn[1]),
    .BTN_D                    (btn[2]),
    .BTN_L                    (btn[4]),
    .BTN_R                    (btn[3]),
    .VGA_HORZ_COORD           (VGA_HORZ_COORD),
    .VGA_VERT_COORD           (VGA_VERT_COORD),
    .Axis_On                  (Axis_On),
    .Grid_On                  (Grid_On),
    .Tick_On                  (Tick_On),
    .Color_Scheme             (Color_Scheme),
    .Menu_Open                (Menu_Open),
    .Cursor_Index             (Cursor_Index),
    .Condition_For_Menu_Box   (Condition_For_Menu_Box),
    .Condition_For_Menu_Border(Condition_For_Menu_Border),
    .Condition_For_Cursor_Menu(Condition_For_Cursor_Menu)
  );

  always #5 CLK_VGA = ~CLK_VGA;

  task automatic chk(input string name, input logic [11:0] got, input int exp);
    n_checks++;
    if (got !== 12'(exp)) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A button level is accepted when the raw input has shown the new level on
  // TB_DEB consecutive clock samples, observed two clocks late; an accepted
  // rising level is a press that acts on the following clock edge.
  bit hist [5][TB_DEB+1];
  bit acc  [5];
  bit pend [5];
  int m_open, m_cur, m_axis, m_grid, m_tick, m_scheme;
  int m_box, m_border, m_hl;

  function automatic void pix(input int open, input int cur, input int x, input int y,
                              output int box, output int border, output int hl);
    int x0, y0, x1, y1, rt;
    x0 = 40; y0 = 40; x1 = 40 + 240; y1 = 40 + 4 * 32;
    rt = y0 + cur * 32;
    box    = (open != 0 && x >= x0 && x < x1 && y >= y0 && y < y1) ? 1 : 0;
    border = (box != 0 && (x < x0 + 2 || x >= x1 - 2 || y < y0 + 2 || y >= y1 - 2)) ? 1 : 0;
    hl     = (open != 0 && border == 0 && y >= rt + 2 && y < rt + 32 - 2 &&
              x >= x0 + 2 && x < x1 - 2) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_open = 0; m_cur = 0; m_axis = 1; m_grid = 1; m_tick = 1; m_scheme = 0;
    m_box = 0; m_border = 0; m_hl = 0;
    for (int b = 0; b < 5; b++) begin
      acc[b] = 0; pend[b] = 0;
      for (int i = 0; i <= TB_DEB; i++) hist[b][i] = 0;
    end
  endtask

  always @(posedge CLK_VGA or negedge RESET_N) begin
    if (!RESET_N) begin
      model_reset();
    end else begin
      pix(m_open, m_cur, int'(VGA_HORZ_COORD), int'(VGA_VERT_COORD), m_box, m_border, m_hl);
      if (pend[0]) m_open = 1 - m_open;
      else if (m_open != 0) begin
        if (pend[1]) m_cur = (m_cur + 3) % 4;
        else if (pend[2]) m_cur = (m_cur + 1) % 4;
        else if (pend[3] || pend[4]) begin
          case (m_cur)
            0: m_axis = 1 - m_axis;
            1: m_grid = 1 - m_grid;
            2: m_tick = 1 - m_tick;
            default: m_scheme = (m_scheme + (pend[3] ? 1 : 3)) % 4;
          endcase
        end
      end
      for (int b = 0; b < 5; b++) begin
        bit target;
        bit held;
        target = !acc[b];
        held = 1;
        for (int i = 1; i <= TB_DEB; i++) if (hist[b][i] != target) held = 0;
        pend[b] = 0;
        if (held) begin
          acc[b] = target;
          pend[b] = target;
        end
        for (int i = TB_DEB; i >= 1; i--) hist[b][i] = hist[b][i-1];
        hist[b][0] = btn[b];
      end
    end
  end

  always @(negedge CLK_VGA) begin
    chk("axis", {11'd0, Axis_On}, m_axis);
    chk("grid", {11'd0, Grid_On}, m_grid);
    chk("tick", {11'd0, Tick_On}, m_tick);
    chk("scheme", {10'd0, Color_Scheme}, m_scheme);
    chk("open", {11'd0, Menu_Open}, m_open);
    chk("cursor", {10'd0, Cursor_Index}, m_cur);
    chk("box", {11'd0, Condition_For_Menu_Box}, m_box);
    chk("border", {11'd0, Condition_For_Menu_Border}, m_border);
    chk("highlight", {11'd0, Condition_For_Cursor_Menu}, m_hl);
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge CLK_VGA);
    #1;
  endtask

  task automatic press(input int b);
    btn[b] = 1'b1;
    tick(TB_DEB + 4);
    btn[b] = 1'b0;
    tick(TB_DEB + 8);
  endtask

  task automatic set_xy(input int x, input int y);
    VGA_HORZ_COORD = 12'(x);
    VGA_VERT_COORD = 12'(y);
  endtask

  initial begin
    int seen;
    int hold_left;
    logic [4:0] mask;

    tick(3);
    chk("rst_axis", {11'd0, Axis_On}, 1);
    chk("rst_grid", {11'd0, Grid_On}, 1);
    chk("rst_tick", {11'd0, Tick_On}, 1);
    chk("rst_scheme", {10'd0, Color_Scheme}, 0);
    chk("rst_open", {11'd0, Menu_Open}, 0);
    chk("rst_cursor", {10'd0, Cursor_Index}, 0);
    RESET_N = 1'b1;
    tick(2);
    chk("closed_box_50_50", {11'd0, Condition_For_Menu_Box}, 0);

    // Open latency from the raw edge.
    btn[0] = 1'b1;
    seen = 0;
    for (int k = 1; k <= 20 && seen == 0; k++) begin
      @(posedge CLK_VGA); #1;
      if (Menu_Open === 1'b1) seen = k;
    end
    chk("open_latency", 12'(seen), 7);
    tick(3);
    btn[0] = 1'b0;
    tick(12);

    set_xy(40, 40); tick(1);
    chk("box_40_40", {11'd0, Condition_For_Menu_Box}, 1);
    chk("border_40_40", {11'd0, Condition_For_Menu_Border}, 1);
    set_xy(50, 50); tick(1);
    chk("box_50_50", {11'd0, Condition_For_Menu_Box}, 1);
    chk("border_50_50", {11'd0, Condition_For_Menu_Border}, 0);
    chk("hl_50_50", {11'd0, Condition_For_Cursor_Menu}, 1);
    set_xy(50, 80); tick(1);
    chk("hl_50_80", {11'd0, Condition_For_Cursor_Menu}, 0);

    press(1); chk("cursor_wrap_up", {10'd0, Cursor_Index}, 3);
    press(3); chk("scheme_r1", {10'd0, Color_Scheme}, 1);
    press(3); chk("scheme_r2", {10'd0, Color_Scheme}, 2);
    press(4); chk("scheme_l1", {10'd0, Color_Scheme}, 1);
    press(4); chk("scheme_l2", {10'd0, Color_Scheme}, 0);
    press(4); chk("scheme_l3_wrap", {10'd0, Color_Scheme}, 3);

    press(2); chk("cursor_wrap_down", {10'd0, Cursor_Index}, 0);
    press(2); chk("cursor_1", {10'd0, Cursor_Index}, 1);
    press(3); chk("grid_toggle", {11'd0, Grid_On}, 0);
    press(0); chk("closed", {11'd0, Menu_Open}, 0);
    chk("grid_kept", {11'd0, Grid_On}, 0);
    set_xy(50, 80); tick(1);
    chk("closed_box", {11'd0, Condition_For_Menu_Box}, 0);
    chk("closed_hl", {11'd0, Condition_For_Cursor_Menu}, 0);
    set_xy(40, 40); tick(1);
    chk("closed_border", {11'd0, Condition_For_Menu_Border}, 0);
    press(2); chk("closed_ignores_d", {10'd0, Cursor_Index}, 1);

    press(0); chk("reopen", {11'd0, Menu_Open}, 1);
    chk("cursor_retained", {10'd0, Cursor_Index}, 1);
    btn[2] = 1'b1; tick(2); btn[2] = 1'b0; tick(12);
    chk("glitch_ignored", {10'd0, Cursor_Index}, 1);
    btn[1] = 1'b1; btn[2] = 1'b1; tick(TB_DEB + 4);
    btn[1] = 1'b0; btn[2] = 1'b0; tick(12);
    chk("u_beats_d", {10'd0, Cursor_Index}, 0);
    press(2);

    // Asynchronous reset in the middle of a C debounce.
    btn[0] = 1'b1;
    tick(3);
    #1 RESET_N = 1'b0;
    #1;
    chk("async_rst_grid", {11'd0, Grid_On}, 1);
    chk("async_rst_scheme", {10'd0, Color_Scheme}, 0);
    chk("async_rst_open", {11'd0, Menu_Open}, 0);
    chk("async_rst_cursor", {10'd0, Cursor_Index}, 0);
    btn[0] = 1'b0;
    tick(2);
    RESET_N = 1'b1;
    tick(15);
    chk("no_pulse_after_rst", {11'd0, Menu_Open}, 0);

    // Random phase.
    hold_left = 0;
    mask = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (RESET_N == 1'b0) RESET_N = 1'b1;
      else if ($urandom_range(0, 999) == 0) RESET_N = 1'b0;
      if ($urandom_range(0, 7) == 0) set_xy(int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)));
      else set_xy(int'($urandom_range(30, 290)), int'($urandom_range(30, 180)));
      if (hold_left == 0) begin
        mask = 5'($urandom) & 5'($urandom) & 5'($urandom);
        hold_left = int'($urandom_range(1, 14));
      end else begin
        hold_left--;
      end
      btn = mask;
      tick(1);
    end
    btn = '0;
    tick(20);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
